// File: rtl/nes_cart_pkg.sv
// Shared types for NES cartridge bus initiators and the MMC1 serial writer.
package nes_cart_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_CHR0 = 2'd1,
        REG_CHR1 = 2'd2,
        REG_PRG  = 2'd3
    } mmc1_reg_e;

    localparam logic [7:0] MMC1_RESET_DATA = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        RSTW,
        BITW,
        GAP,
        DONE
    } writer_state_e;

endpackage

// File: rtl/cpu_bus_phase.sv
// Free-running CPU bus phase counter producing m2 and a strobe on the clock
// whose edge begins the next bus cycle.
module cpu_bus_phase #(
    parameter int CYC_CLKS = 2
) (
    input  logic clk,
    input  logic rst,
    output logic m2,
    output logic cycle_start
);

    localparam int PW = (CYC_CLKS > 2) ? $clog2(CYC_CLKS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CYC_CLKS - 1);
    localparam logic [PW-1:0] HALF = PW'(CYC_CLKS / 2);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;

    // High on the last phase: the upcoming edge makes phase 0.
    assign cycle_start = (phase == LAST);
    assign phase_nxt   = cycle_start ? '0 : phase + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            m2    <= 1'b0;
        end else begin
            phase <= phase_nxt;
            m2    <= (phase_nxt >= HALF);
        end
    end

endmodule

// File: rtl/mmc1_serial_writer.sv
// Drives the cart CPU bus to load one MMC1 register through the 5-write
// serial protocol, optionally preceded by a shift-register reset write.
module mmc1_serial_writer
    import nes_cart_pkg::*;
#(
    parameter int CYC_CLKS   = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_reg,
    input  logic [4:0]  cmd_data,
    input  logic        cmd_reset,
    output logic        done,
    output logic        busy,
    output logic        m2,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_rw,
    output logic        romsel
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    writer_state_e state, state_nxt;
    mmc1_reg_e     reg_q, reg_nxt;
    logic [4:0]    data_q, data_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          pending, pending_nxt;
    logic [14:0]   addr_nxt;
    logic [7:0]    dout_nxt;
    logic          rw_nxt, romsel_nxt, done_nxt;
    logic          cycle_start;
    logic          accept;

    cpu_bus_phase #(.CYC_CLKS(CYC_CLKS)) u_phase (
        .clk         (clk_cpu),
        .rst         (rst),
        .m2          (m2),
        .cycle_start (cycle_start)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE) && (state != DONE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt   = state;
        reg_nxt     = reg_q;
        data_nxt    = data_q;
        idx_nxt     = idx;
        gap_nxt     = gap_cnt;
        pending_nxt = pending;
        addr_nxt    = cpu_addr;
        dout_nxt    = cpu_data_o;
        rw_nxt      = cpu_rw;
        romsel_nxt  = romsel;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    reg_nxt     = mmc1_reg_e'(cmd_reg);
                    data_nxt    = cmd_data;
                    idx_nxt     = 3'd0;
                    state_nxt   = cmd_reset ? RSTW : BITW;
                    // Accepted on the last phase: the write owns the very next cycle.
                    pending_nxt = !cycle_start;
                    if (cycle_start) begin
                        addr_nxt   = {cmd_reg, 13'h0};
                        rw_nxt     = 1'b0;
                        romsel_nxt = 1'b0;
                        dout_nxt   = cmd_reset ? MMC1_RESET_DATA : {7'b0, cmd_data[0]};
                    end
                end
            end
            RSTW, BITW: begin
                if (cycle_start) begin
                    if (pending) begin
                        pending_nxt = 1'b0;
                        addr_nxt    = {reg_q, 13'h0};
                        rw_nxt      = 1'b0;
                        romsel_nxt  = 1'b0;
                        dout_nxt    = (state == RSTW) ? MMC1_RESET_DATA : {7'b0, data_q[idx]};
                    end else begin
                        rw_nxt     = 1'b1;
                        romsel_nxt = 1'b1;
                        gap_nxt    = GW'(GAP_CYCLES - 1);
                        if (state == BITW && idx == 3'd4) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = GAP;
                            if (state == BITW)
                                idx_nxt = (idx >= 3'd4) ? 3'd4 : idx + 3'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (cycle_start) begin
                    if (gap_cnt == '0) begin
                        state_nxt  = BITW;
                        addr_nxt   = {reg_q, 13'h0};
                        rw_nxt     = 1'b0;
                        romsel_nxt = 1'b0;
                        dout_nxt   = {7'b0, data_q[idx]};
                    end else begin
                        gap_nxt = gap_cnt - 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state      <= IDLE;
            reg_q      <= REG_CTRL;
            data_q     <= '0;
            idx        <= '0;
            gap_cnt    <= '0;
            pending    <= 1'b0;
            cpu_addr   <= '0;
            cpu_data_o <= '0;
            cpu_rw     <= 1'b1;
            romsel     <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            reg_q      <= reg_nxt;
            data_q     <= data_nxt;
            idx        <= idx_nxt;
            gap_cnt    <= gap_nxt;
            pending    <= pending_nxt;
            cpu_addr   <= addr_nxt;
            cpu_data_o <= dout_nxt;
            cpu_rw     <= rw_nxt;
            romsel     <= romsel_nxt;
            done       <= done_nxt;
        end
    end

endmodule
